// File: rtl/bt656_rx_decoder.sv
// bt656_rx_decoder
// Decodes a BT.656 8-bit YCbCr 4:2:2 byte stream into a 16-bit {Y,C} beat
// stream with start-of-field (m_tuser) and end-of-line (m_tlast) markers.
// Input bytes are qualified by data_valid_i; idle cycles stall all decoding.
//
// Optional build macro: BT656_PARITY_CHECK_EN
//   defined   - timing-reference XY byte is checked (bit 7 and P3..P0);
//               bad headers are consumed, flagged on hdr_err_o and ignored.
//   undefined - XY[7] and XY[3:0] are ignored; hdr_err_o stays 0.
module bt656_rx_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       data_i,
    input  logic             data_valid_i,
    output logic [15:0]      m_tdata,
    output logic             m_tvalid,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             field_o,
    output logic             vblank_o,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic             line_err_o,
    output logic             hdr_err_o
);

    localparam int                BEAT_W    = $clog2(H_ACTIVE + 1);
    localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(H_ACTIVE);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_BLANK,
        ST_ACTIVE
    } state_t;

    // Lookahead window: win_q[0] is the newest byte, win_q[3] the oldest.
    logic [7:0]        win_q [4];
    logic [3:0]        win_tag_q;
    logic [1:0]        skip_q;

    state_t            state_q;
    logic              phase_q;      // 0: chroma byte expected, 1: luma byte
    logic [7:0]        chroma_q;
    logic [BEAT_W-1:0] beat_q;
    logic              sof_pend_q;

    logic [15:0]       tdata_q;
    logic              tvalid_q;
    logic              tuser_q;
    logic              tlast_q;
    logic              field_q;
    logic              vblank_q;
    logic [CNT_W-1:0]  line_cnt_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic              line_err_q;
    logic              hdr_err_q;

    logic              hdr_det;
    logic              hdr_ok;
    logic              data_shift;
    logic              xy_f;
    logic              xy_v;
    logic              xy_h;

    assign xy_f = win_q[0][6];
    assign xy_v = win_q[0][5];
    assign xy_h = win_q[0][4];

    // Shift the window and run the header-skip counter on every valid byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the window is only four bytes, so it is cleared along with
            // its tags; a larger buffer would rely on the tags alone.
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= '0;
            end
            win_tag_q <= '0;
            skip_q    <= '0;
        end else if (data_valid_i) begin
            win_q[0]  <= data_i;
            win_q[1]  <= win_q[0];
            win_q[2]  <= win_q[1];
            win_q[3]  <= win_q[2];
            win_tag_q <= {win_tag_q[2:0], 1'b1};
            if (hdr_det) begin
                skip_q <= 2'd3;
            end else if (skip_q != 2'd0) begin
                skip_q <= skip_q - 2'd1;
            end
        end
    end

    // Classify the byte leaving the window: header start, data, or skipped.
    always_comb begin
        hdr_det    = 1'b0;
        data_shift = 1'b0;
        if (data_valid_i && (skip_q == 2'd0)) begin
            hdr_det    = (&win_tag_q) && (win_q[3] == 8'hFF) &&
                         (win_q[2] == 8'h00) && (win_q[1] == 8'h00);
            data_shift = win_tag_q[3] && !hdr_det;
        end
    end

`ifdef BT656_PARITY_CHECK_EN
    assign hdr_ok = win_q[0][7] &&
                    (win_q[0][3:0] == {xy_v ^ xy_h, xy_f ^ xy_h,
                                       xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
`else
    assign hdr_ok = 1'b1;
`endif

    // Line/field state machine, beat assembly and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_SEARCH;
            phase_q     <= 1'b0;
            chroma_q    <= '0;
            beat_q      <= '0;
            sof_pend_q  <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
            field_q     <= 1'b0;
            vblank_q    <= 1'b0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
            hdr_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read below
            // sees the value from before this edge and later defaults are
            // simply overridden by the specific branches.
            tvalid_q   <= 1'b0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
            line_err_q <= 1'b0;
            hdr_err_q  <= 1'b0;

            if (hdr_det) begin
                if (!hdr_ok) begin
                    hdr_err_q <= 1'b1;
                end else begin
                    field_q  <= xy_f;
                    vblank_q <= xy_v;
                    // A V=0 header after V=1 arms start-of-field; it survives
                    // the EAV of the first active line until its SAV data.
                    if (xy_v) begin
                        sof_pend_q <= 1'b0;
                    end else if (vblank_q) begin
                        sof_pend_q <= 1'b1;
                    end
                    if (xy_h) begin
                        state_q <= ST_BLANK;
                        if ((state_q == ST_ACTIVE) && (beat_q != BEAT_FULL)) begin
                            line_err_q <= 1'b1;
                        end
                    end else if (xy_v) begin
                        state_q <= ST_BLANK;
                    end else begin
                        state_q <= ST_ACTIVE;
                        phase_q <= 1'b0;
                        beat_q  <= '0;
                    end
                end
            end else if (data_shift && (state_q == ST_ACTIVE)) begin
                phase_q <= ~phase_q;
                if (!phase_q) begin
                    chroma_q <= win_q[3];
                end else if (beat_q < BEAT_FULL) begin
                    tdata_q  <= {win_q[3], chroma_q};
                    tvalid_q <= 1'b1;
                    tuser_q  <= sof_pend_q;
                    tlast_q  <= (beat_q == BEAT_LAST);
                    beat_q   <= beat_q + 1'b1;
                    if (sof_pend_q) begin
                        sof_pend_q <= 1'b0;
                        line_cnt_q <= (beat_q == BEAT_LAST) ? CNT_W'(1) : '0;
                        if (!field_q) begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end else if ((beat_q == BEAT_LAST) && (line_cnt_q != '1)) begin
                        line_cnt_q <= line_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign m_tdata     = tdata_q;
    assign m_tvalid    = tvalid_q;
    assign m_tuser     = tuser_q;
    assign m_tlast     = tlast_q;
    assign field_o     = field_q;
    assign vblank_o    = vblank_q;
    assign line_cnt_o  = line_cnt_q;
    assign frame_cnt_o = frame_cnt_q;
    assign line_err_o  = line_err_q;
    assign hdr_err_o   = hdr_err_q;

endmodule

// File: tb/tb_bt656_rx_decoder.sv
// tb_bt656_rx_decoder
// Table of line-level vectors (header bytes, beat count, pacing -> expected
// counts and status) plus hand-written sequences for reset mid-line and
// FF/truncated-header bytes inside active video.
module tb_bt656_rx_decoder;

    localparam int H_ACTIVE = 640;
    localparam int CNT_W    = 12;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [7:0]       data_i = 8'h00;
    logic             data_valid_i = 1'b0;
    logic [15:0]      m_tdata;
    logic             m_tvalid;
    logic             m_tuser;
    logic             m_tlast;
    logic             field_o;
    logic             vblank_o;
    logic [CNT_W-1:0] line_cnt_o;
    logic [CNT_W-1:0] frame_cnt_o;
    logic             line_err_o;
    logic             hdr_err_o;

    always #5 clk = ~clk;

    bt656_rx_decoder #(
        .H_ACTIVE (H_ACTIVE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tuser      (m_tuser),
        .m_tlast      (m_tlast),
        .field_o      (field_o),
        .vblank_o     (vblank_o),
        .line_cnt_o   (line_cnt_o),
        .frame_cnt_o  (frame_cnt_o),
        .line_err_o   (line_err_o),
        .hdr_err_o    (hdr_err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Beat k of a test line: C = 0x80 + k%64, Y = k%250 + 1 (never 00 or FF).
    function automatic logic [15:0] exp_beat(input int k);
        logic [7:0] y;
        logic [7:0] c;
        c = 8'(8'h80 + (k % 64));
        y = 8'(1 + (k % 250));
        return {y, c};
    endfunction

    // ---------------- output monitor (cumulative counters) ----------------
    int          mon_beats    = 0;
    int          mon_tuser    = 0;
    int          mon_tlast    = 0;
    int          mon_line_err = 0;
    int          mon_hdr_err  = 0;
    int          mon_data_err = 0;
    int          mon_pos_err  = 0;
    int          base_beats   = 0;
    bit          chk_pattern  = 1'b1;
    int          cyc          = 0;
    int          last_cyc     = 0;
    int          gap_min      = 0;
    int          gap_max      = 0;
    int          mk           = 0;
    int          mg           = 0;
    logic [15:0] last_tdata   = 16'h0;
    logic [15:0] prev_tdata   = 16'h0;

    always @(negedge clk) begin
        cyc++;
        if (m_tvalid) begin
            mk = mon_beats - base_beats;
            if (chk_pattern && (m_tdata !== exp_beat(mk))) mon_data_err++;
            if (m_tuser && (mk != 0)) mon_pos_err++;
            if (m_tlast && (mk != H_ACTIVE - 1)) mon_pos_err++;
            if (mk == 0) begin
                gap_min = 1 << 30;
                gap_max = 0;
            end else begin
                mg = cyc - last_cyc;
                if (mg < gap_min) gap_min = mg;
                if (mg > gap_max) gap_max = mg;
            end
            last_cyc   = cyc;
            prev_tdata = last_tdata;
            last_tdata = m_tdata;
            mon_beats++;
            if (m_tuser) mon_tuser++;
            if (m_tlast) mon_tlast++;
        end
        if (line_err_o) mon_line_err++;
        if (hdr_err_o)  mon_hdr_err++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input logic [7:0] b, input bit gap);
        @(negedge clk);
        data_i       = b;
        data_valid_i = 1'b1;
        if (gap) begin
            @(negedge clk);
            data_valid_i = 1'b0;
            data_i       = 8'hFF;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_valid_i = 1'b0;
        end
    endtask

    task automatic put_hdr(input logic [7:0] xy, input bit gap);
        put(8'hFF, gap);
        put(8'h00, gap);
        put(8'h00, gap);
        put(xy, gap);
    endtask

    task automatic put_beats(input int first, input int n, input bit gap);
        logic [15:0] w;
        for (int k = first; k < first + n; k++) begin
            w = exp_beat(k);
            put(w[7:0], gap);
            put(w[15:8], gap);
        end
    endtask

    task automatic send_line(input logic [7:0] sav, input int n,
                             input logic [7:0] eav, input bit gap);
        put_hdr(sav, gap);
        put_beats(0, n, gap);
        put_hdr(eav, gap);
        for (int i = 0; i < 4; i++) put(8'h10, gap);
        idle(6);
    endtask

    function automatic bit outs_zero();
        return ({m_tdata, m_tvalid, m_tuser, m_tlast, field_o, vblank_o,
                 line_cnt_o, frame_cnt_o, line_err_o, hdr_err_o} == '0);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] sav;
        int         n;
        logic [7:0] eav;
        bit         gap;
        int         beats;
        int         tuser;
        int         tlast;
        int         lerr;
        int         herr;
        int         f;
        int         v;
        int         lcnt;
        int         fcnt;
        int         gap_exp;
    } vec_t;

    vec_t vecs [9];

    int b0, u0, l0, e0, h0, d0, p0;

    initial begin
        //                sav    n    eav   gap beats tu tl le he f v lc fc gap
        vecs[0] = '{8'hAB,   4, 8'hB6, 1'b0,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[1] = '{8'h80, 640, 8'h9D, 1'b0, 640, 1, 1, 0, 0, 0, 0, 1, 1, 2};
        vecs[2] = '{8'h80, 640, 8'h9D, 1'b0, 640, 0, 1, 0, 0, 0, 0, 2, 1, 2};
        vecs[3] = '{8'h80, 638, 8'h9D, 1'b0, 638, 0, 0, 1, 0, 0, 0, 2, 1, 2};
        vecs[4] = '{8'h80, 643, 8'h9D, 1'b0, 640, 0, 1, 0, 0, 0, 0, 3, 1, 2};
        vecs[5] = '{8'hEC,   4, 8'hF1, 1'b0,   0, 0, 0, 0, 0, 1, 1, 3, 1, 0};
        vecs[6] = '{8'hC7, 640, 8'hDA, 1'b0, 640, 1, 1, 0, 0, 1, 0, 1, 1, 2};
        vecs[7] = '{8'hC7, 640, 8'hDA, 1'b1, 640, 0, 1, 0, 0, 1, 0, 2, 1, 4};
`ifdef BT656_PARITY_CHECK_EN
        vecs[8] = '{8'h81,   8, 8'h9D, 1'b0,   0, 0, 0, 0, 1, 0, 0, 2, 1, 0};
`else
        vecs[8] = '{8'h81,   8, 8'h9D, 1'b0,   8, 0, 0, 1, 0, 0, 0, 2, 1, 2};
`endif

        // ---- reset state ----
        idle(3);
        check("reset outputs zero", outs_zero(), 1);
        rstn = 1'b1;

        // ---- reset in the middle of an active line ----
        base_beats = mon_beats;
        put_hdr(8'h80, 1'b0);
        put_beats(0, 100, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        data_valid_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("mid-line reset outputs zero", outs_zero(), 1);
        check("beats before mid-line reset", (mon_beats - base_beats) > 90, 1);
        b0 = mon_beats;
        put_beats(100, 20, 1'b0);
        idle(6);
        check("no beats after reset before SAV", mon_beats - b0, 0);
        check("outputs still zero after reset", outs_zero(), 1);
        base_beats = mon_beats;
        b0 = mon_beats; u0 = mon_tuser; e0 = mon_line_err; d0 = mon_data_err;
        send_line(8'h80, 8, 8'h9D, 1'b0);
        check("post-reset line beats", mon_beats - b0, 8);
        check("post-reset line data errors", mon_data_err - d0, 0);
        check("post-reset line tuser", mon_tuser - u0, 0);
        check("post-reset short line err", mon_line_err - e0, 1);

        // ---- table-driven lines ----
        for (int i = 0; i < 9; i++) begin
            base_beats = mon_beats;
            b0 = mon_beats; u0 = mon_tuser; l0 = mon_tlast;
            e0 = mon_line_err; h0 = mon_hdr_err; d0 = mon_data_err; p0 = mon_pos_err;
            send_line(vecs[i].sav, vecs[i].n, vecs[i].eav, vecs[i].gap);
            check($sformatf("v%0d beats", i),      mon_beats - b0,    vecs[i].beats);
            check($sformatf("v%0d tuser", i),      mon_tuser - u0,    vecs[i].tuser);
            check($sformatf("v%0d tlast", i),      mon_tlast - l0,    vecs[i].tlast);
            check($sformatf("v%0d line_err", i),   mon_line_err - e0, vecs[i].lerr);
            check($sformatf("v%0d hdr_err", i),    mon_hdr_err - h0,  vecs[i].herr);
            check($sformatf("v%0d data", i),       mon_data_err - d0, 0);
            check($sformatf("v%0d marker pos", i), mon_pos_err - p0,  0);
            check($sformatf("v%0d field_o", i),    field_o,           vecs[i].f);
            check($sformatf("v%0d vblank_o", i),   vblank_o,          vecs[i].v);
            check($sformatf("v%0d line_cnt_o", i), line_cnt_o,        vecs[i].lcnt);
            check($sformatf("v%0d frame_cnt_o", i), frame_cnt_o,      vecs[i].fcnt);
            if (vecs[i].gap_exp != 0) begin
                check($sformatf("v%0d beat gap min", i), gap_min, vecs[i].gap_exp);
                check($sformatf("v%0d beat gap max", i), gap_max, vecs[i].gap_exp);
            end
        end

        // ---- FF as data and truncated header inside an active line ----
        chk_pattern = 1'b0;
        base_beats  = mon_beats;
        b0 = mon_beats;
        put_hdr(8'h80, 1'b0);
        put(8'hFF, 1'b0);
        put(8'h00, 1'b0);
        put(8'h55, 1'b0);
        put(8'h10, 1'b0);
        put_hdr(8'h9D, 1'b0);
        for (int i = 0; i < 4; i++) put(8'h10, 1'b0);
        idle(6);
        check("truncated header beats", mon_beats - b0, 2);
        check("FF chroma beat data", prev_tdata, 16'h00FF);
        check("post-truncation beat data", last_tdata, 16'h1055);
        chk_pattern = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
